// File: rtl/activation_array.sv
// activation_array
//   Array of NUM_CH integrate-and-fire channels. It accepts one input-current
//   vector per timestep through a valid/ready handshake. Each channel
//   integrates the current into a saturating membrane potential. A channel
//   fires when the potential reaches its signed threshold, then resets to the
//   remainder (soft) or to zero (hard). Spikes are counted over a window of
//   num_steps timesteps, and a run/done FSM sequences the window.
//
// Ports
//   clk, rstn            clock, asynchronous active-low reset
//   start                pulse: clear channel state, latch num_steps/reset_mode
//   num_steps            timesteps per window (sampled on start)
//   reset_mode           0 = soft (subtract threshold), 1 = hard (to zero)
//   threshold            packed signed per-channel thresholds
//   membrane_potential   packed unsigned per-channel input currents
//   in_valid / in_ready  timestep handshake
//   out_valid/out_spike  registered per-step spike vector (one-cycle pulse)
//   accumulated_spikes   packed saturating per-channel spike counts
//   busy / done          window in progress / window complete
//
// state   | meaning
// --------+---------------------------------------------------------
// ST_IDLE | no window programmed since reset; inputs ignored
// ST_RUN  | window active; each in_valid cycle is one timestep
// ST_DONE | window complete; counts frozen until the next start

module activation_array #(
    parameter int NUM_CH      = 32,
    parameter int DATA_WIDTH  = 16,
    parameter int TIMER_WIDTH = 5
) (
    input  logic                          clk,
    input  logic                          rstn,
    input  logic                          start,
    input  logic [TIMER_WIDTH-1:0]        num_steps,
    input  logic                          reset_mode,
    input  logic [NUM_CH*DATA_WIDTH-1:0]  threshold,
    input  logic [NUM_CH*DATA_WIDTH-1:0]  membrane_potential,
    input  logic                          in_valid,
    output logic                          in_ready,
    output logic                          out_valid,
    output logic [NUM_CH-1:0]             out_spike,
    output logic [NUM_CH*TIMER_WIDTH-1:0] accumulated_spikes,
    output logic                          busy,
    output logic                          done
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t                 state_q, state_d;
    logic [TIMER_WIDTH-1:0] num_q, num_d;
    logic [TIMER_WIDTH-1:0] step_q, step_d;
    logic                   mode_q, mode_d;
    logic                   valid_q, valid_d;
    logic [TIMER_WIDTH-1:0] step_inc;
    logic                   accept;

    // start wins over a simultaneous in_valid, so that step is never taken.
    assign accept   = (state_q == ST_RUN) && in_valid && !start;
    assign step_inc = step_q + 1'b1;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= ST_IDLE;
            num_q   <= '0;
            step_q  <= '0;
            mode_q  <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            num_q   <= num_d;
            step_q  <= step_d;
            mode_q  <= mode_d;
            valid_q <= valid_d;
        end
    end

    always_comb begin
        state_d = state_q;
        num_d   = num_q;
        step_d  = step_q;
        mode_d  = mode_q;
        valid_d = 1'b0;
        if (start) begin
            num_d   = num_steps;
            mode_d  = reset_mode;
            step_d  = '0;
            state_d = (num_steps == '0) ? ST_DONE : ST_RUN;
        end else if (accept) begin
            step_d  = step_inc;
            valid_d = 1'b1;
            // step_q stays below num_q while running, so step_inc never wraps here
            if (step_inc == num_q) begin
                state_d = ST_DONE;
            end
        end
    end

    assign in_ready  = (state_q == ST_RUN);
    assign busy      = (state_q == ST_RUN);
    assign done      = (state_q == ST_DONE);
    assign out_valid = valid_q;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        logic signed [DATA_WIDTH-1:0] thr;
        logic [DATA_WIDTH-1:0]        cur;
        logic [DATA_WIDTH:0]          sum;
        logic [DATA_WIDTH:0]          rem;
        logic [DATA_WIDTH-1:0]        pot_q, pot_d;
        logic [TIMER_WIDTH-1:0]       cnt_q, cnt_d;
        logic                         spike_q, spike_d;

        assign thr = threshold[g*DATA_WIDTH +: DATA_WIDTH];
        assign cur = membrane_potential[g*DATA_WIDTH +: DATA_WIDTH];
        assign sum = {1'b0, pot_q} + {1'b0, cur};
        // Only used when thr is positive, so the zero-extended threshold is exact.
        assign rem = sum - {1'b0, thr};

        always_comb begin
            spike_d = 1'b0;
            pot_d   = pot_q;
            cnt_d   = cnt_q;
            if (thr[DATA_WIDTH-1] || (thr == '0)) begin
                pot_d = '0;
            end else if (sum >= {1'b0, thr}) begin
                spike_d = 1'b1;
                if (mode_q) begin
                    pot_d = '0;
                end else begin
                    pot_d = rem[DATA_WIDTH] ? '1 : rem[DATA_WIDTH-1:0];
                end
                if (cnt_q != '1) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end else begin
                pot_d = sum[DATA_WIDTH] ? '1 : sum[DATA_WIDTH-1:0];
            end
        end

        always_ff @(posedge clk or negedge rstn) begin
            if (!rstn) begin
                pot_q   <= '0;
                cnt_q   <= '0;
                spike_q <= 1'b0;
            end else if (start) begin
                pot_q   <= '0;
                cnt_q   <= '0;
                spike_q <= 1'b0;
            end else if (accept) begin
                pot_q   <= pot_d;
                cnt_q   <= cnt_d;
                spike_q <= spike_d;
            end
        end

        assign out_spike[g]                                   = spike_q;
        assign accumulated_spikes[g*TIMER_WIDTH +: TIMER_WIDTH] = cnt_q;
    end

endmodule

// File: doc/activation_array.md
Name: activation_array

Overview:
- Parametrised, stateful successor to the fixed 32-channel activation unit.
- Holds NUM_CH integrate-and-fire channels behind packed vector ports. Each channel integrates an input current per timestep, compares it against a per-channel threshold, fires and resets (soft or hard), and counts spikes over a programmed timestep window.
- Sits between the systolic array's partial-sum outputs and the spike-count readout path, with a valid/ready timestep handshake and a run/done control FSM.

Parameters:
- NUM_CH, 32, number of neuron channels.
- DATA_WIDTH, 16, width of threshold, input current and internal membrane potential.
- TIMER_WIDTH, 5, width of spike counters and of the timestep window length.

Ports:
- clk  input  1  clock.
- rstn  input  1  asynchronous active-low reset.
- start  input  1  pulse: clear all channel state, latch num_steps, begin window.
- num_steps  input  TIMER_WIDTH  timesteps per window; sampled when start=1.
- reset_mode  input  1  0 = soft reset (subtract threshold), 1 = hard reset (to zero); sampled when start=1.
- threshold  input  NUM_CH*DATA_WIDTH  packed signed thresholds; channel i at [i*DATA_WIDTH +: DATA_WIDTH].
- membrane_potential  input  NUM_CH*DATA_WIDTH  packed unsigned input currents, same packing.
- in_valid  input  1  input current vector valid for one timestep.
- in_ready  output  1  array accepts a timestep.
- out_valid  output  1  out_spike is valid (one-cycle pulse).
- out_spike  output  NUM_CH  per-channel spike for the accepted timestep.
- accumulated_spikes  output  NUM_CH*TIMER_WIDTH  packed per-channel spike counts.
- busy  output  1  window in progress.
- done  output  1  window complete; counts are final.

Behaviour:
- Reset (rstn=0, asynchronous):
  - FSM to IDLE.
  - All potentials, spike counters, step counter, out_spike, out_valid, busy and done cleared to 0.
  - Latched num_steps and reset_mode cleared to 0.
  - A reset asserted mid-window aborts the window with no done pulse.
- FSM states IDLE, RUN, DONE:
  - IDLE: in_ready=0, busy=0, done=0. start -> RUN, or -> DONE if num_steps==0 (all counts 0).
  - RUN: in_ready=1, busy=1. Each cycle with in_valid && in_ready is one timestep; the step counter increments. When the step counter reaches the latched num_steps on an accepted step, the next state is DONE.
  - DONE: in_ready=0, busy=0, done=1 (level), and accumulated_spikes is held. start -> RUN (or DONE if num_steps==0) with a full clear.
- start has priority in every state. start in RUN aborts and restarts; a simultaneous in_valid is ignored (not accepted).
- Per-channel update on an accepted step, with V = stored potential (unsigned DATA_WIDTH) and I = input current:
  - S = V + I computed in DATA_WIDTH+1 bits.
  - If threshold is less than or equal to 0 (signed), the channel is disabled: no spike, and V is set to 0.
  - Else if S >= threshold, the channel spikes. Soft reset gives V = min(S - threshold, 2^DATA_WIDTH-1); hard reset gives V = 0.
  - Else V = min(S, 2^DATA_WIDTH-1) (saturating integrate, no wrap).
- out_spike and out_valid are registered: one-cycle latency after acceptance. out_valid pulses once per accepted step, including the final step, which coincides with the cycle done rises. out_spike holds its last value when out_valid=0.
- Spike counters increment on a spike and saturate at 2^TIMER_WIDTH-1 (never wrap). They update in the same edge as out_spike.
- accumulated_spikes is registered and always visible; it is final only when done=1.
- No backpressure on outputs: the consumer must take out_spike on out_valid.
- in_valid outside RUN is ignored.

Test Plan:
- Reset: assert rstn=0 mid-RUN after 3 steps -> all outputs 0 immediately; after release, IDLE with in_ready=0 and no done pulse.
- Soft reset: NUM_CH=4, threshold ch0=10, I=4 constant, num_steps=5, reset_mode=0 -> ch0 spikes at steps 3 and 5 (potential after step 3 is 2). accumulated_spikes ch0=2, done=1 one cycle after the fifth acceptance.
- Hard reset: same stimulus with reset_mode=1 -> spikes at step 3 only (potential 0 then 4, 8), count=1.
- Disabled channel: threshold ch1=0 and ch2=-5, I=0xFFFF -> no spikes, counts 0. Meanwhile ch3 with threshold=1, I=0xFFFF and num_steps=31 -> count saturates at 31; potential saturates at 0xFFFF with no wrap.
- Handshake and restart: in_valid toggling 1,0,1 with num_steps=2 -> exactly 2 out_valid pulses, done after the second. Then start with num_steps=0 -> done=1 the next cycle, counts 0. Then start during RUN with in_valid=1 -> step not counted, counters cleared.
